demux4_dispatch_5: RTL and testbench

Registered 1-to-4 demultiplexer for 5-bit data: the distribution-side counterpart of the 4-to-1 5-bit selector in the datapath element library. A single producer offers one 5-bit word per cycle. The block steers it into one of four output holding registers, chosen either by an explicit select or by an internal round-robin pointer. Each output channel has its own valid/ack handshake, so four independent consumers can drain at their own pace.

---
 rtl/demux4_dispatch_5.sv | 72 +++++++
 tb/tb_demux4_dispatch_5.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_dispatch_5.sv
// Registered 1-to-4 demultiplexer: steers one W-bit word per cycle into one of four
// holding registers chosen by explicit select or round-robin pointer, each with valid/ack.
module demux4_dispatch_5 #(
  parameter int W     = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [1:0]       s,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     o0,
  output logic [W-1:0]     o1,
  output logic [W-1:0]     o2,
  output logic [W-1:0]     o3,
  output logic [3:0]       v,
  input  logic [3:0]       ack,
  output logic [1:0]       ptr,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     r_o [4];
  logic [3:0]       r_v;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_count;

  logic [1:0] w_target;
  logic       w_ready;
  logic       w_accept;
  logic [3:0] w_wr;
  logic [3:0] w_clr;

  // A full channel still accepts when its consumer acks in the same cycle.
  always_comb begin
    w_target = mode ? r_ptr : s;
    w_ready  = ~r_v[w_target] | ack[w_target];
    w_accept = in_valid & w_ready;
    w_wr     = w_accept ? (4'b0001 << w_target) : 4'b0000;
    w_clr    = ack & r_v & ~w_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_o[i] <= '0;
      r_v     <= 4'b0000;
      r_ptr   <= 2'd0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr[i]) r_o[i] <= din;
      end
      // Write wins over a same-channel ack.
      r_v <= (r_v & ~w_clr) | w_wr;
      if (w_accept) begin
        r_count <= r_count + CNT_W'(1);
        if (mode) r_ptr <= r_ptr + 2'd1;
      end
    end
  end

  assign in_ready = w_ready;
  assign o0       = r_o[0];
  assign o1       = r_o[1];
  assign o2       = r_o[2];
  assign o3       = r_o[3];
  assign v        = r_v;
  assign ptr      = r_ptr;
  assign count    = r_count;

endmodule

// File: tb/tb_demux4_dispatch_5.sv
// Self-checking bench for demux4_dispatch_5: directed scenarios plus random traffic
// compared against a behavioural channel/queue model.
module tb_demux4_dispatch_5;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       mode;
  logic [1:0] s;
  logic [4:0] din;
  logic [4:0] o0, o1, o2, o3;
  logic [3:0] v;
  logic [3:0] ack;
  logic [1:0] ptr;
  logic [7:0] count;

  demux4_dispatch_5 #(.W(5), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .s(s), .din(din),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3),
    .v(v), .ack(ack), .ptr(ptr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: channel contents, occupancy flags, pointer and counter.
  int m_o [4];
  bit m_v [4];
  int m_ptr;
  int m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_target();
    return mode ? m_ptr : int'(s);
  endfunction

  function automatic bit m_ready();
    int t;
    t = m_target();
    return !m_v[t] || ack[t];
  endfunction

  function automatic logic [3:0] m_vbits();
    return {m_v[3], m_v[2], m_v[1], m_v[0]};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_o[i] = 0;
      m_v[i] = 0;
    end
    m_ptr   = 0;
    m_count = 0;
  endtask

  task automatic m_clock();
    int t;
    bit acc;
    t   = m_target();
    acc = in_valid && m_ready();
    for (int i = 0; i < 4; i++) begin
      if (acc && i == t) begin
        m_o[i] = int'(din);
        m_v[i] = 1;
      end else if (ack[i]) begin
        m_v[i] = 0;
      end
    end
    if (acc) begin
      m_count = (m_count + 1) % 256;
      if (mode) m_ptr = (m_ptr + 1) % 4;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".o0"}, 32'(o0), 32'(m_o[0]));
    chk({tag, ".o1"}, 32'(o1), 32'(m_o[1]));
    chk({tag, ".o2"}, 32'(o2), 32'(m_o[2]));
    chk({tag, ".o3"}, 32'(o3), 32'(m_o[3]));
    chk({tag, ".v"}, 32'(v), 32'(m_vbits()));
    chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
    chk({tag, ".count"}, 32'(count), 32'(m_count));
  endtask

  // Inputs are already driven; check readiness before the edge, then state after it.
  task automatic step(input string tag);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
    @(posedge clk);
    m_clock();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit iv, input bit md, input logic [1:0] sel,
                       input logic [4:0] d, input logic [3:0] a);
    in_valid = iv;
    mode     = md;
    s        = sel;
    din      = d;
    ack      = a;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    compare_all(tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 2'd0, 5'd0, 4'b0000);
    m_reset();
    #3;
    compare_all("por");
    do_reset("rst0");

    // Explicit select fills all four channels
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 2'(i), 5'(i + 1), 4'b0000);
      step("sel");
    end
    chk("sel.o0_const", 32'(o0), 32'd1);
    chk("sel.o3_const", 32'(o3), 32'd4);
    chk("sel.v_const", 32'(v), 32'hF);
    chk("sel.count_const", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 2'(i), 5'd0, 4'b0000);
      #1;
      chk("full.in_ready", 32'(in_ready), 32'd0);
    end

    // Backpressure, then same-cycle ack bypass on channel 1
    drive(1, 0, 2'd1, 5'd9, 4'b0000);
    step("bp");
    chk("bp.o1_const", 32'(o1), 32'd2);
    drive(1, 0, 2'd1, 5'd9, 4'b0010);
    step("byp");
    chk("byp.o1_const", 32'(o1), 32'd9);
    chk("byp.v_const", 32'(v), 32'hF);

    // Independent acks, then ack on an empty channel
    drive(0, 0, 2'd0, 5'd0, 4'b0101);
    step("iack");
    chk("iack.v_const", 32'(v), 32'hA);
    drive(0, 0, 2'd0, 5'd0, 4'b0001);
    step("eack");
    chk("eack.o0_const", 32'(o0), 32'd1);

    // Async reset mid-run with v=1011
    drive(0, 0, 2'd0, 5'd0, 4'b1111);
    step("drain");
    drive(1, 0, 2'd0, 5'd17, 4'b0000); step("ld0");
    drive(1, 0, 2'd1, 5'd18, 4'b0000); step("ld1");
    drive(1, 0, 2'd3, 5'd19, 4'b0000); step("ld3");
    chk("ld.v_const", 32'(v), 32'hB);
    drive(1, 0, 2'd2, 5'd20, 4'b0000);
    do_reset("rstmid");
    drive(0, 0, 2'd0, 5'd0, 4'b0000);

    // Round-robin with continuous acks
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 2'd3, 5'(i + 5), 4'b1111);
      step("rr");
    end
    chk("rr.ptr_const", 32'(ptr), 32'd2);
    chk("rr.count_const", 32'(count), 32'd6);
    chk("rr.o0_const", 32'(o0), 32'd9);
    chk("rr.o1_const", 32'(o1), 32'd10);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 5'($urandom), 4'($urandom));
      step("rnd");
    end

    // Counter wrap after 256 accepts in round-robin
    do_reset("rst2");
    for (int i = 0; i < 256; i++) begin
      drive(1, 1, 2'd0, 5'($urandom), 4'b1111);
      step("wrap");
    end
    chk("wrap.count_const", 32'(count), 32'd0);
    chk("wrap.ptr_const", 32'(ptr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
